// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_adder_pkg;

   // Controller state encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2, used to size the bit counter
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   // Sum and carry of one bit position
   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder and a carry flop process
// one bit per cycle, LSB first, behind a start/busy/done handshake.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int            CW       = clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   // Holds the low WIDTH-1 result bits; the MSB is produced on the final edge
   logic [WIDTH-2:0] res;
   logic [WIDTH-1:0] res_nxt;
   logic             carry;
   logic             msb_cin;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_cout;

   full_adder u_fa (
      .a    (opa[0]),
      .b    (opb[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // Result register after this cycle's bit shifts in at the MSB
   assign res_nxt = {fa_s, res};

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Controller plus serial datapath; outputs only move on the final bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         opa      <= '0;
         opb      <= '0;
         res      <= '0;
         carry    <= 1'b0;
         msb_cin  <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  // Subtract as a + ~b + 1: invert b, seed carry with 1
                  opa   <= a;
                  opb   <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               opa   <= {1'b0, opa[WIDTH-1:1]};
               opb   <= {1'b0, opb[WIDTH-1:1]};
               res   <= res_nxt[WIDTH-1:1];
               carry <= fa_cout;
               cnt   <= cnt + 1'b1;
               // Carry out of bit WIDTH-2 is the carry into the MSB
               if (cnt == CNT_MSB) msb_cin <= fa_cout;
               if (cnt == CNT_LAST) begin
                  sum      <= res_nxt;
                  cout     <= fa_cout;
                  overflow <= msb_cin ^ fa_cout;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8).
module tb_serial_adder;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk;
   logic         reset;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic from the two's-complement definition
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t         e;
      logic [W:0]   full;
      if (s) full = {1'b0, x} + {1'b0, ~y} + 1;
      else   full = {1'b0, x} + {1'b0, y};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      if (s) e.ovf = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
      else   e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
      return e;
   endfunction

   // Scoreboard: compare every done pulse against the oldest expectation
   always @(negedge clk) begin
      if (!reset) begin
         chk("busy_done_excl", {31'd0, busy & done}, 0);
         if (done) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("sum", {24'd0, sum}, {24'd0, e.sum});
               chk("cout", {31'd0, cout}, {31'd0, e.cout});
               chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
            end
         end
      end
   end

   // Issue one op and check handshake timing; result checked by scoreboard
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      int nb;
      int lat;
      bit seen;
      start = 1'b1; a = x; b = y; sub = s;
      sb_q.push_back(model(x, y, s));
      @(posedge clk); #1;
      start = 1'b0;
      nb = 0; lat = -1; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; lat = i; end
         else if (busy) nb++;
      end
      chk("done_seen", {31'd0, seen}, 1);
      chk("latency", lat, 8);
      chk("busy_cycles", nb, 8);
      @(posedge clk); #1;
   endtask

   initial begin
      int   pulses;
      int   last_done;
      int   cyc;
      bit   prev_done;
      reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_sum", {24'd0, sum}, 0);
      chk("rst_cout", {31'd0, cout}, 0);
      chk("rst_ovf", {31'd0, overflow}, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      do_op(8'd200, 8'd100, 1'b0);
      do_op(8'd100, 8'd100, 1'b0);
      do_op(8'd5,   8'd7,   1'b1);
      do_op(8'h80,  8'h01,  1'b1);
      do_op(8'd9,   8'd9,   1'b1);
      for (int i = 0; i < 6; i++)
         do_op(W'($urandom_range(255)), W'($urandom_range(255)), 1'($urandom_range(1)));

      // start during RUN must be ignored
      start = 1'b1; a = 8'd100; b = 8'd27; sub = 1'b0;
      sb_q.push_back(model(8'd100, 8'd27, 1'b0));
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1; a = 8'd1; b = 8'd2; sub = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("ignored_start_drained", sb_q.size(), 0);

      // Asynchronous reset in the middle of RUN
      start = 1'b1; a = 8'd50; b = 8'd60; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_busy", {31'd0, busy}, 1);
      reset = 1'b1;
      #1;
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_done", {31'd0, done}, 0);
      chk("arst_sum", {24'd0, sum}, 0);
      chk("arst_cout", {31'd0, cout}, 0);
      chk("arst_ovf", {31'd0, overflow}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(negedge clk) chk("no_done_after_rst", {31'd0, done}, 0);
      @(posedge clk); #1;
      do_op(8'd3, 8'd4, 1'b0);

      // start held high: results every W+1 cycles, sum stable in between
      start = 1'b1; a = 8'd1; b = 8'd1; sub = 1'b0;
      for (int i = 0; i < 4; i++) sb_q.push_back(model(8'd1, 8'd1, 1'b0));
      pulses = 0; last_done = -1; prev_done = 0;
      for (cyc = 0; cyc < 60 && pulses < 4; cyc++) begin
         @(negedge clk);
         if (prev_done) chk("busy_after_done", {31'd0, busy}, 1);
         if (done) begin
            if (last_done >= 0) chk("done_period", cyc - last_done, W + 1);
            last_done = cyc;
            pulses++;
         end else if (pulses == 0) begin
            chk("sum_hold_start", {24'd0, sum}, 7);
         end else begin
            chk("sum_hold", {24'd0, sum}, 2);
         end
         prev_done = done;
      end
      start = 1'b0;
      chk("hold_pulses", pulses, 4);
      repeat (12) @(posedge clk);
      #1;
      chk("queue_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor: the sequential successor to the team's single-bit combinational adders. It computes an N-bit sum or difference over N cycles using one full-adder cell and a carry flip-flop, behind a start/busy/done handshake. It sits in the SNUBoard datapath wherever area matters more than latency, for example switch-driven arithmetic demos feeding the 7-segment display.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled on the rising edge of clk.
- sub  input  1  0 = a+b, 1 = a-b; sampled together with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of the MSB; in subtract mode, 1 means no borrow (a >= b unsigned).
- overflow  output  1  two's-complement overflow of the result.

## Operation
- The clock is clk. Reset is asynchronous and active-high on the reset port.
- States:
  - IDLE: waiting for start.
  - RUN: processing one bit per cycle.
  - DONE: single cycle with done high.
- IDLE or DONE, with start=1:
  - Load the operand shift registers with a and (sub ? ~b : b).
  - Load the carry flip-flop with sub.
  - Clear the bit counter and go to RUN.
- DONE, with start=0: go to IDLE.
- RUN, each edge:
  - The full adder combines the operand LSBs with the carry.
  - The result bit shifts into the MSB of an internal result shift register.
  - Both operand registers shift right, the carry flip-flop takes the carry-out, and the counter increments.
- RUN, edge processing bit WIDTH-1:
  - sum is loaded from the completed result register.
  - cout is loaded with the final carry.
  - overflow is loaded with (carry into the MSB) XOR (carry out of the MSB).
  - State goes to DONE.
- Outputs sum, cout and overflow change only on that edge. They hold until the next completion, and they do not change when a new start is accepted.
- start in RUN is ignored, including its a, b and sub values.
- Arithmetic is modulo 2^WIDTH. The counter is ceil(log2(WIDTH)) bits wide, with terminal count WIDTH-1.

## Timing
- Reset (asynchronous, any state including mid-RUN):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal registers are cleared.
  - The in-flight operation is discarded, with no done pulse.
- Latency, with start accepted at edge k:
  - busy is high during the cycles following edges k … k+WIDTH-1.
  - The result is registered at edge k+WIDTH.
  - done is high for exactly the cycle following edge k+WIDTH.
- Throughput: start asserted in the DONE cycle is accepted at edge k+WIDTH+1. Back-to-back operations therefore complete every WIDTH+1 cycles. done stays a single-cycle pulse, and busy rises again one cycle later.
- busy and done are decoded directly from the state register. They are never high together.

## Structure
- A shared package serial_adder_pkg holds:
  - the state encoding constants IDLE, RUN, DONE (2-bit);
  - a counter-width function clog2.
- Sub-module full_adder (inputs a, b, cin; outputs s, cout) is instantiated once. It is the only combinational arithmetic in the block.
- Top level contains:
  - the FSM;
  - two operand shift registers;
  - the result shift register;
  - the carry flip-flop and the MSB carry-in capture flip-flop;
  - the counter;
  - the output registers.

## Test plan
All scenarios use WIDTH=8.
- Add 200+100 → done at start+8 edges; sum=44, cout=1, overflow=0; busy high exactly 8 cycles.
- Add 100+100 → sum=200, cout=0, overflow=1. Subtract 5−7 → sum=0xFE, cout=0, overflow=0.
- Subtract 0x80−0x01 → sum=0x7F, cout=1, overflow=1. Subtract 9−9 → sum=0, cout=1, overflow=0.
- start pulsed with new operands at cycle 3 of RUN → ignored; the first result is unchanged and only one done pulse occurs.
- reset asserted at RUN cycle 4 → all outputs 0 immediately (asynchronous), no done pulse, state IDLE. The next operation (3+4) gives sum=7.
- start held high continuously with a=1, b=1 → done pulses every 9 cycles, sum=2 each time. sum holds between pulses.
